alu_issue_stage: RTL and testbench
==================================

# alu_issue_stage

Decode-and-issue stage that produces the `alu_ctrl` code and operand pair consumed by the integer ALU (arithmetic, logical and shift units). It accepts RV32I OP/OP-IMM instructions with their source register values over a valid/ready handshake, decodes opcode/funct3/funct7 into a 4-bit ALU control code, and substitutes the sign-extended immediate for `rs2` on OP-IMM. Output is registered, with a one-entry skid buffer so both handshakes run at full throughput.

## Interface

- `XLEN`, 32, operand width.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  reset; one clock; reset is asynchronous and active-low.
- `in_valid`  input  1  instruction and operands present.
- `in_ready`  output  1  stage can accept this cycle.
- `in_instr`  input  32  raw instruction word.
- `in_rs1`  input  XLEN  source register 1 value.
- `in_rs2`  input  XLEN  source register 2 value; ignored for OP-IMM.
- `out_valid`  output  1  issued op present.
- `out_ready`  input  1  ALU accepts this cycle.
- `out_alu_ctrl`  output  4  ALU control code.
- `out_rs1`  output  XLEN  operand A.
- `out_rs2`  output  XLEN  operand B (register or immediate).
- `out_rd`  output  5  destination register index, `in_instr[11:7]`.
- `out_illegal`  output  1  instruction not decodable to an ALU op.

## Operation

- ALU control codes: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001, ILLEGAL 1111.
- OP (opcode 0110011): funct3 000/001/010/011/100/101/110/111 -> ADD-or-SUB/SLL/SLT/SLTU/XOR/SRL-or-SRA/OR/AND. funct7 must be 0000000, except 0100000 allowed with funct3 000 (SUB) and 101 (SRA); otherwise illegal.
- OP-IMM (opcode 0010011): same funct3 map, no SUB. `out_rs2` = sign-extended `in_instr[31:20]`. For SLLI/SRLI/SRAI, `out_rs2` = zero-extended shamt `in_instr[24:20]`; `in_instr[31:25]` must be 0000000 (0100000 allowed for SRAI only), otherwise illegal.
- Any other opcode: illegal.
- Illegal: `out_alu_ctrl` = 1111, `out_illegal` = 1, operands passed unchanged, op still issued (downstream logical unit yields 0 for unknown codes; trap handling is downstream).
- Storage: output register (OR) plus skid register (SK), each with a valid bit.
- `in_ready` = !SK.valid.
- Accept (`in_valid && in_ready`): if OR empty or OR drains this cycle -> decoded op to OR; else -> SK.
- Drain (`out_valid && out_ready`): OR <- SK if SK.valid (SK cleared), else OR cleared unless simultaneously loaded from input.
- Payload registers change only on load; `out_*` payload is held stable while `out_valid && !out_ready`.

## Timing

- Reset (async assert, sync deassert): OR.valid = SK.valid = 0; `out_valid` = 0, `in_ready` = 1, `out_alu_ctrl` = 0000, `out_rs1` = `out_rs2` = 0, `out_rd` = 0, `out_illegal` = 0.
- Latency: accepted op visible on `out_*` the cycle after acceptance.
- Throughput: one op/cycle with `out_ready` held high.
- Back-pressure: with `out_ready` low, two ops accepted (OR, SK), then `in_ready` = 0 from the cycle after SK fills. `in_ready` depends only on registered state, with no combinational path from `out_ready`.
- Simultaneous accept and drain with SK full cannot occur (`in_ready` = 0).
- Reset mid-operation: both entries discarded immediately; no partial op issued.

## Structure

- `alu_pkg`: `alu_ctrl_t` 4-bit codes above, opcode constants `OPC_OP`/`OPC_OP_IMM`, funct7 constants.
- Combinational sub-module `alu_ctrl_decoder` (instr in -> alu_ctrl, use_imm, imm, illegal). Handshake/skid logic stays in `alu_issue_stage`.
- The ALU units import `alu_pkg`, so codes stay consistent.

## Test plan

- Reset: after `rst_n` low, `out_valid` = 0, `in_ready` = 1, all payload outputs 0.
- `and x3,x1,x2` (0x0020F1B3), rs1 = 0xF0F0F0F0, rs2 = 0x0FF00FF0, `out_ready` = 1 -> next cycle: ctrl 0010, rs2 0x0FF00FF0, rd 3, illegal 0.
- `xori x5,x6,-1` (0xFFF34293) -> ctrl 0100, `out_rs2` = 0xFFFFFFFF. `srai x1,x1,4` (0x4040D093) -> ctrl 0111, `out_rs2` = 0x00000004.
- funct7 = 0100000 with funct3 110 (OR), and opcode 0000011 -> ctrl 1111, illegal 1, op still issued.
- `out_ready` low, three back-to-back ops A, B, C -> A, B accepted, `in_ready` = 0, C held. Release -> A, B, C issued in order on consecutive cycles, payload stable while stalled.
- Async reset asserted with OR and SK full -> `out_valid` drops without a clock. After release, no stale op appears.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the integer ALU and its issue stage: the 4-bit ALU
// control codes, the RV32I major opcodes handled here, the legal funct7
// patterns, and the funct3 -> control-code map common to OP and OP-IMM.
// The ALU units import this package so control codes stay consistent.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD     = 4'b0000,
        ALU_SUB     = 4'b0001,
        ALU_AND     = 4'b0010,
        ALU_OR      = 4'b0011,
        ALU_XOR     = 4'b0100,
        ALU_SLL     = 4'b0101,
        ALU_SRL     = 4'b0110,
        ALU_SRA     = 4'b0111,
        ALU_SLT     = 4'b1000,
        ALU_SLTU    = 4'b1001,
        ALU_ILLEGAL = 4'b1111
    } alu_ctrl_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    // Selects SUB (funct3 000) and SRA/SRAI (funct3 101)
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Base funct3 map; funct7-dependent variants are resolved by the decoder.
    function automatic alu_ctrl_t f3_ctrl(input logic [2:0] funct3);
        case (funct3)
            3'b000:  return ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// alu_issue_stage_if
// Handshake bundle around the issue stage.
//   Input side : in_valid, in_ready, in_instr, in_rs1, in_rs2
//   Output side: out_valid, out_ready, out_alu_ctrl, out_rs1, out_rs2,
//                out_rd, out_illegal
// master: the environment (upstream producer + downstream ALU).
// slave : the issue stage itself.
interface alu_issue_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_rs1;
    logic [XLEN-1:0] in_rs2;

    logic            out_valid;
    logic            out_ready;
    logic [3:0]      out_alu_ctrl;
    logic [XLEN-1:0] out_rs1;
    logic [XLEN-1:0] out_rs2;
    logic [4:0]      out_rd;
    logic            out_illegal;

    modport master (
        output in_valid, in_instr, in_rs1, in_rs2, out_ready,
        input  in_ready, out_valid, out_alu_ctrl, out_rs1, out_rs2,
               out_rd, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, in_rs1, in_rs2, out_ready,
        output in_ready, out_valid, out_alu_ctrl, out_rs1, out_rs2,
               out_rd, out_illegal
    );
endinterface

// File: rtl/alu_ctrl_decoder.sv
// alu_ctrl_decoder
// Purely combinational RV32I OP/OP-IMM decoder.
//   instr    : raw instruction word
//   alu_ctrl : ALU control code (ALU_ILLEGAL when not decodable)
//   use_imm  : operand B comes from imm rather than rs2 (legal OP-IMM only)
//   imm      : sign-extended I-immediate, or zero-extended shamt for shifts
//   rd       : destination register index
//   illegal  : instruction is not an ALU op
module alu_ctrl_decoder
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]            instr,
    output alu_ctrl_t              alu_ctrl,
    output logic                   use_imm,
    output logic signed [XLEN-1:0] imm,
    output logic [4:0]             rd,
    output logic                   illegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_rs1_idx;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign rd     = instr[11:7];
    // rs1 index is resolved by the register file, not here
    assign unused_rs1_idx = ^instr[19:15];

    always_comb begin
        alu_ctrl = ALU_ILLEGAL;
        use_imm  = 1'b0;
        illegal  = 1'b1;
        imm      = {{(XLEN-12){instr[31]}}, instr[31:20]};

        case (opcode)
            OPC_OP: begin
                if (funct7 == F7_ZERO) begin
                    alu_ctrl = f3_ctrl(funct3);
                    illegal  = 1'b0;
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    alu_ctrl = ALU_SUB;
                    illegal  = 1'b0;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    alu_ctrl = ALU_SRA;
                    illegal  = 1'b0;
                end
            end
            OPC_OP_IMM: begin
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    // Shift-immediates: upper bits are funct7, not immediate
                    imm = {{(XLEN-5){1'b0}}, instr[24:20]};
                    if (funct7 == F7_ZERO) begin
                        alu_ctrl = f3_ctrl(funct3);
                        use_imm  = 1'b1;
                        illegal  = 1'b0;
                    end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                        alu_ctrl = ALU_SRA;
                        use_imm  = 1'b1;
                        illegal  = 1'b0;
                    end
                end else begin
                    alu_ctrl = f3_ctrl(funct3);
                    use_imm  = 1'b1;
                    illegal  = 1'b0;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage
// Decode-and-issue stage feeding the integer ALU. Decodes an incoming
// OP/OP-IMM instruction, picks operand B (rs2 or immediate) and registers the
// result into an output register (OR) backed by a one-entry skid register
// (SK), so both handshakes sustain one op per cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : alu_issue_stage_if slave (in_* handshake, out_* handshake)
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_issue_stage_if.slave     bus
);

    alu_ctrl_t              ctrl_p0;
    logic                   use_imm_p0;
    logic signed [XLEN-1:0] imm_p0;
    logic [4:0]             rd_p0;
    logic                   illegal_p0;
    logic [XLEN-1:0]        rs2_p0;

    alu_ctrl_decoder #(.XLEN(XLEN)) u_dec (
        .instr    (bus.in_instr),
        .alu_ctrl (ctrl_p0),
        .use_imm  (use_imm_p0),
        .imm      (imm_p0),
        .rd       (rd_p0),
        .illegal  (illegal_p0)
    );

    // Illegal ops keep rs2 unchanged because use_imm is only set when legal
    assign rs2_p0 = use_imm_p0 ? $unsigned(imm_p0) : bus.in_rs2;

    // ---- stage boundary: decode -> output/skid registers ----
    logic            or_vld_p1;
    alu_ctrl_t       or_ctrl_p1;
    logic [XLEN-1:0] or_rs1_p1;
    logic [XLEN-1:0] or_rs2_p1;
    logic [4:0]      or_rd_p1;
    logic            or_ill_p1;

    logic            sk_vld_p1;
    alu_ctrl_t       sk_ctrl_p1;
    logic [XLEN-1:0] sk_rs1_p1;
    logic [XLEN-1:0] sk_rs2_p1;
    logic [4:0]      sk_rd_p1;
    logic            sk_ill_p1;

    logic accept;
    logic drain;
    logic or_load_in;
    logic or_load_sk;
    logic sk_load;

    // in_ready is a pure register output: no path from out_ready
    assign bus.in_ready = !sk_vld_p1;
    assign accept       = bus.in_valid && !sk_vld_p1;
    assign drain        = or_vld_p1 && bus.out_ready;
    assign or_load_in   = accept && (!or_vld_p1 || drain);
    assign sk_load      = accept && or_vld_p1 && !drain;
    // accept is impossible while SK is full, so or_load_sk and or_load_in
    // never coincide
    assign or_load_sk   = drain && sk_vld_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            or_vld_p1  <= 1'b0;
            or_ctrl_p1 <= ALU_ADD;
            or_rs1_p1  <= '0;
            or_rs2_p1  <= '0;
            or_rd_p1   <= '0;
            or_ill_p1  <= 1'b0;
            sk_vld_p1  <= 1'b0;
            sk_ctrl_p1 <= ALU_ADD;
            sk_rs1_p1  <= '0;
            sk_rs2_p1  <= '0;
            sk_rd_p1   <= '0;
            sk_ill_p1  <= 1'b0;
        end else begin
            if (or_load_sk) begin
                or_vld_p1  <= 1'b1;
                or_ctrl_p1 <= sk_ctrl_p1;
                or_rs1_p1  <= sk_rs1_p1;
                or_rs2_p1  <= sk_rs2_p1;
                or_rd_p1   <= sk_rd_p1;
                or_ill_p1  <= sk_ill_p1;
            end else if (or_load_in) begin
                or_vld_p1  <= 1'b1;
                or_ctrl_p1 <= ctrl_p0;
                or_rs1_p1  <= bus.in_rs1;
                or_rs2_p1  <= rs2_p0;
                or_rd_p1   <= rd_p0;
                or_ill_p1  <= illegal_p0;
            end else if (drain) begin
                or_vld_p1  <= 1'b0;
            end

            if (sk_load) begin
                sk_vld_p1  <= 1'b1;
                sk_ctrl_p1 <= ctrl_p0;
                sk_rs1_p1  <= bus.in_rs1;
                sk_rs2_p1  <= rs2_p0;
                sk_rd_p1   <= rd_p0;
                sk_ill_p1  <= illegal_p0;
            end else if (or_load_sk) begin
                sk_vld_p1  <= 1'b0;
            end
        end
    end

    assign bus.out_valid    = or_vld_p1;
    assign bus.out_alu_ctrl = or_ctrl_p1;
    assign bus.out_rs1      = or_rs1_p1;
    assign bus.out_rs2      = or_rs2_p1;
    assign bus.out_rd       = or_rd_p1;
    assign bus.out_illegal  = or_ill_p1;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage
// Directed bench for alu_issue_stage: reset values, decode of several
// instruction forms, illegal handling, back-pressure through the skid
// register and asynchronous reset with both entries full.
module tb_alu_issue_stage;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    alu_issue_stage_if #(.XLEN(32)) bus ();

    alu_issue_stage #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; return 1 time unit after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] instr,
                         input logic [31:0] rs1, input logic [31:0] rs2);
        bus.in_valid = v;
        bus.in_instr = instr;
        bus.in_rs1   = rs1;
        bus.in_rs2   = rs2;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 32'h0);

        // Reset state
        step();
        chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
        chk("rst_ctrl", {28'b0, bus.out_alu_ctrl}, 32'd0);
        chk("rst_rs1", bus.out_rs1, 32'h0);
        chk("rst_rs2", bus.out_rs2, 32'h0);
        chk("rst_rd", {27'b0, bus.out_rd}, 32'd0);
        chk("rst_illegal", {31'b0, bus.out_illegal}, 32'd0);
        rst_n = 1'b1;
        step();

        // Full-throughput stream with out_ready high
        bus.out_ready = 1'b1;
        drive(1'b1, 32'h0020F1B3, 32'hF0F0F0F0, 32'h0FF00FF0);   // and x3,x1,x2
        step();
        chk("and_valid", {31'b0, bus.out_valid}, 32'd1);
        chk("and_ctrl", {28'b0, bus.out_alu_ctrl}, 32'h2);
        chk("and_rs1", bus.out_rs1, 32'hF0F0F0F0);
        chk("and_rs2", bus.out_rs2, 32'h0FF00FF0);
        chk("and_rd", {27'b0, bus.out_rd}, 32'd3);
        chk("and_illegal", {31'b0, bus.out_illegal}, 32'd0);

        drive(1'b1, 32'hFFF34293, 32'h11111111, 32'h12345678);   // xori x5,x6,-1
        step();
        chk("xori_valid", {31'b0, bus.out_valid}, 32'd1);
        chk("xori_ctrl", {28'b0, bus.out_alu_ctrl}, 32'h4);
        chk("xori_rs2", bus.out_rs2, 32'hFFFFFFFF);
        chk("xori_rd", {27'b0, bus.out_rd}, 32'd5);

        drive(1'b1, 32'h4040D093, 32'h80000000, 32'hDEADBEEF);   // srai x1,x1,4
        step();
        chk("srai_ctrl", {28'b0, bus.out_alu_ctrl}, 32'h7);
        chk("srai_rs2", bus.out_rs2, 32'h00000004);
        chk("srai_illegal", {31'b0, bus.out_illegal}, 32'd0);

        drive(1'b1, 32'h402081B3, 32'h5, 32'h3);                 // sub x3,x1,x2
        step();
        chk("sub_ctrl", {28'b0, bus.out_alu_ctrl}, 32'h1);
        chk("sub_rs2", bus.out_rs2, 32'h3);

        drive(1'b1, 32'h4020E1B3, 32'hAAAA0000, 32'h0000BBBB);   // OR with funct7 0100000
        step();
        chk("ill_or_valid", {31'b0, bus.out_valid}, 32'd1);
        chk("ill_or_ctrl", {28'b0, bus.out_alu_ctrl}, 32'hF);
        chk("ill_or_illegal", {31'b0, bus.out_illegal}, 32'd1);
        chk("ill_or_rs1", bus.out_rs1, 32'hAAAA0000);
        chk("ill_or_rs2", bus.out_rs2, 32'h0000BBBB);

        drive(1'b1, 32'h0000A183, 32'h1, 32'h2);                 // lw: opcode 0000011
        step();
        chk("ill_ld_ctrl", {28'b0, bus.out_alu_ctrl}, 32'hF);
        chk("ill_ld_illegal", {31'b0, bus.out_illegal}, 32'd1);
        chk("ill_ld_rs2", bus.out_rs2, 32'h2);
        chk("ill_ld_rd", {27'b0, bus.out_rd}, 32'd3);

        drive(1'b0, 32'h0, 32'h0, 32'h0);
        step();
        chk("drain_empty", {31'b0, bus.out_valid}, 32'd0);

        // Back-pressure: A, B, C offered back to back with out_ready low
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h0020F1B3, 32'hA, 32'h1A);
        step();
        chk("bp_A_in_ready", {31'b0, bus.in_ready}, 32'd1);
        chk("bp_A_out", bus.out_rs1, 32'hA);
        drive(1'b1, 32'h0020F1B3, 32'hB, 32'h1B);
        step();
        chk("bp_B_in_ready", {31'b0, bus.in_ready}, 32'd0);
        chk("bp_B_hold_rs1", bus.out_rs1, 32'hA);
        drive(1'b1, 32'h0020F1B3, 32'hC, 32'h1C);
        step();
        chk("bp_C_in_ready", {31'b0, bus.in_ready}, 32'd0);
        chk("bp_C_hold_rs1", bus.out_rs1, 32'hA);
        chk("bp_C_hold_rs2", bus.out_rs2, 32'h1A);
        chk("bp_C_valid", {31'b0, bus.out_valid}, 32'd1);

        bus.out_ready = 1'b1;
        step();
        chk("rel_B_rs1", bus.out_rs1, 32'hB);
        chk("rel_B_in_ready", {31'b0, bus.in_ready}, 32'd1);
        step();
        chk("rel_C_rs1", bus.out_rs1, 32'hC);
        chk("rel_C_valid", {31'b0, bus.out_valid}, 32'd1);
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        step();
        chk("rel_empty", {31'b0, bus.out_valid}, 32'd0);

        // Async reset with OR and SK both full
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h0020F1B3, 32'h77, 32'h0);
        step();
        drive(1'b1, 32'h0020F1B3, 32'h88, 32'h0);
        step();
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        chk("ar_full_in_ready", {31'b0, bus.in_ready}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("ar_in_ready", {31'b0, bus.in_ready}, 32'd1);
        chk("ar_rs1", bus.out_rs1, 32'h0);
        step();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        step();
        chk("ar_post1_valid", {31'b0, bus.out_valid}, 32'd0);
        step();
        chk("ar_post2_valid", {31'b0, bus.out_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
